// File: rtl/operand_fetch_pkg.sv
// Shared RV32 types, opcode encodings and instruction field helpers for the
// operand-fetch stage.
package operand_fetch_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  addr_t;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011
    } opcode_t;

    localparam word_t NOP = 32'h0000_0013;

    typedef struct packed {
        word_t pc;
        word_t inst;
        word_t op1;
        word_t op2;
    } of_payload_t;

    function automatic addr_t get_rs1(input word_t inst);
        get_rs1 = inst[19:15];
    endfunction

    function automatic addr_t get_rs2(input word_t inst);
        get_rs2 = inst[24:20];
    endfunction

    function automatic addr_t get_rd(input word_t inst);
        get_rd = inst[11:7];
    endfunction

    function automatic opcode_t get_opcode(input word_t inst);
        get_opcode = opcode_t'(inst[6:0]);
    endfunction

    // Unknown opcodes are treated as reading rs1 so a hazard is never missed.
    function automatic logic uses_rs1(input word_t inst);
        case (get_opcode(inst))
            LUI, AUIPC, JAL: uses_rs1 = 1'b0;
            default:         uses_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input word_t inst);
        case (get_opcode(inst))
            BRANCH, STORE, OP: uses_rs2 = 1'b1;
            default:           uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Fetch-side and execute-side valid/ready channels of the operand-fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_pc;
    word_t in_inst;

    logic  out_valid;
    logic  out_ready;
    word_t out_pc;
    word_t out_inst;
    word_t out_rs1;
    word_t out_rs2;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2
    );

endinterface

// File: rtl/operand_fetch_bypass_mux.sv
// Per-read-port operand selection: EX result, then MEM result, then regfile
// data, with x0 pinned to zero.
module operand_fetch_bypass_mux
    import operand_fetch_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  addr_t rs_i,
    input  logic  used_i,
    input  word_t rdata_i,
    input  logic  ex_wen_i,
    input  addr_t ex_waddr_i,
    input  word_t ex_wdata_i,
    input  logic  mem_wen_i,
    input  addr_t mem_waddr_i,
    input  word_t mem_wdata_i,
    output word_t operand_o,
    output logic  ex_match_o,
    output logic  mem_match_o
);

    assign ex_match_o  = ex_wen_i  && (ex_waddr_i  == rs_i) && (rs_i != '0) && used_i;
    assign mem_match_o = mem_wen_i && (mem_waddr_i == rs_i) && (rs_i != '0) && used_i;

    // Without bypassing the top stalls on any match, so regfile data is final.
    always_comb begin
        operand_o = rdata_i;
        if (rs_i == '0) begin
            operand_o = '0;
        end else if (BYPASS_EN && ex_match_o) begin
            operand_o = ex_wdata_i;
        end else if (BYPASS_EN && mem_match_o) begin
            operand_o = mem_wdata_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: resolves source operands with EX/MEM bypass,
// stalls on load-use hazards and registers the result for execute.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flush,
    operand_fetch_if.slave bus,
    output addr_t raddr1,
    input  word_t rdata1,
    output addr_t raddr2,
    input  word_t rdata2,
    input  logic  ex_wen,
    input  logic  ex_load,
    input  addr_t ex_waddr,
    input  word_t ex_wdata,
    input  logic  mem_wen,
    input  addr_t mem_waddr,
    input  word_t mem_wdata
);

    word_t       inst;
    logic        use1;
    logic        use2;
    word_t       operand1;
    word_t       operand2;
    logic        exMatch1;
    logic        exMatch2;
    logic        memMatch1;
    logic        memMatch2;
    logic        exHit;
    logic        memHit;
    logic        stall;
    logic        advance;

    logic        valid_q;
    logic        valid_d;
    of_payload_t payload_q;
    of_payload_t payload_d;

    assign inst   = bus.in_inst;
    assign use1   = uses_rs1(inst);
    assign use2   = uses_rs2(inst);
    assign raddr1 = get_rs1(inst);
    assign raddr2 = get_rs2(inst);

    operand_fetch_bypass_mux #(.BYPASS_EN(BYPASS_EN)) u_mux1 (
        .rs_i        (raddr1),
        .used_i      (use1),
        .rdata_i     (rdata1),
        .ex_wen_i    (ex_wen),
        .ex_waddr_i  (ex_waddr),
        .ex_wdata_i  (ex_wdata),
        .mem_wen_i   (mem_wen),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .operand_o   (operand1),
        .ex_match_o  (exMatch1),
        .mem_match_o (memMatch1)
    );

    operand_fetch_bypass_mux #(.BYPASS_EN(BYPASS_EN)) u_mux2 (
        .rs_i        (raddr2),
        .used_i      (use2),
        .rdata_i     (rdata2),
        .ex_wen_i    (ex_wen),
        .ex_waddr_i  (ex_waddr),
        .ex_wdata_i  (ex_wdata),
        .mem_wen_i   (mem_wen),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .operand_o   (operand2),
        .ex_match_o  (exMatch2),
        .mem_match_o (memMatch2)
    );

    assign exHit   = exMatch1 || exMatch2;
    assign memHit  = memMatch1 || memMatch2;
    assign stall   = bus.in_valid &&
                     ((ex_load && exHit) || (!BYPASS_EN && (exHit || memHit)));
    assign advance = !valid_q || bus.out_ready;

    // A flush always consumes the incoming instruction so fetch can redirect.
    assign bus.in_ready = flush || (advance && !stall);

    // Payload only moves when a real instruction is captured; bubbles leave it alone.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = bus.in_valid && !stall;
            if (bus.in_valid && !stall) begin
                payload_d.pc   = bus.in_pc;
                payload_d.inst = inst;
                payload_d.op1  = operand1;
                payload_d.op2  = operand2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= 1'b0;
            payload_q.pc   <= '0;
            payload_q.inst <= NOP;
            payload_q.op1  <= '0;
            payload_q.op2  <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_pc    = payload_q.pc;
    assign bus.out_inst  = payload_q.inst;
    assign bus.out_rs1   = payload_q.op1;
    assign bus.out_rs2   = payload_q.op2;

endmodule
